// File: rtl/image_scan_controller.sv
// -----------------------------------------------------------------------------
// image_scan_controller
//   Walks (column,row) across one frame in raster order, drives the RGB
//   loader's coordinate inputs, absorbs the loader's fixed read latency with a
//   tag pipeline and presents the pixels as a valid/ready stream with
//   start-of-frame / end-of-line / end-of-frame markers.
//
// Optional feature (macro SCAN_FRAME_REPEAT_EN):
//   Adds input repeat_frame ("repeat" is a reserved word). When it is high as
//   the last coordinate of a frame issues, scanning wraps to (0,0) and
//   continues without a gap; done pulses once per completed frame.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        frame start pulse / cancel-and-flush pulse
//   busy, done          frame in progress / one-cycle completion pulse
//   rd_column, rd_row   coordinate to the loader (registered)
//   rd_pixel            loader pixel {B,G,R}, READ_LATENCY cycles behind
//   m_valid, m_ready    output stream handshake
//   m_pixel             output pixel
//   m_sof, m_eol, m_eof markers qualifying m_pixel
// -----------------------------------------------------------------------------
module image_scan_controller #(
   parameter int IMAGE_WIDTH  = 116,
   parameter int IMAGE_HEIGHT = 78,
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4    // >= READ_LATENCY+1, power of 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
`ifdef SCAN_FRAME_REPEAT_EN
   input  logic        repeat_frame,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] rd_column,
   output logic [31:0] rd_row,
   input  logic [23:0] rd_pixel,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [23:0] m_pixel,
   output logic        m_sof,
   output logic        m_eol,
   output logic        m_eof
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   state_t state;

   // Tag pipeline, one stage per cycle of loader latency: {valid,sof,eol,eof}
   logic [READ_LATENCY-1:0][3:0] pipe;
   logic [READ_LATENCY-1:0]      stage_valid;

   logic [26:0]   mem [FIFO_DEPTH];   // {pixel, sof, eol, eof}
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic        push, pop, issue, flush;
   logic        last_col, last_row, repeat_now, head_eof;
   logic [26:0] head;
   logic [3:0]  issue_tag;
   logic [31:0] in_flight;

`ifdef SCAN_FRAME_REPEAT_EN
   assign repeat_now = repeat_frame;
`else
   assign repeat_now = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < READ_LATENCY; gi++) begin : g_stage_valid
         assign stage_valid[gi] = pipe[gi][3];
      end
   endgenerate

   always_comb begin
      in_flight = '0;
      for (int i = 0; i < READ_LATENCY; i++)
         in_flight = in_flight + 32'(stage_valid[i]);
   end

   assign head      = mem[rd_ptr];
   assign head_eof  = head[0];
   assign m_valid   = (count != '0);
   assign pop       = m_valid && m_ready;
   assign push      = pipe[READ_LATENCY-1][3];
   assign flush     = abort && (state != IDLE);
   assign last_col  = (rd_column == 32'(IMAGE_WIDTH - 1));
   assign last_row  = (rd_row == 32'(IMAGE_HEIGHT - 1));
   assign issue_tag = {1'b1, (rd_column == '0) && (rd_row == '0), last_col, last_col && last_row};

   // Reserve a FIFO slot for every read in flight; a pop this cycle frees one.
   assign issue = (state == ISSUE) &&
                  (in_flight + 32'(count) + 32'd1 <= 32'(FIFO_DEPTH) + 32'(pop));

   // Empty FIFO shows zeros rather than stale storage.
   assign m_pixel = m_valid ? head[26:3] : 24'd0;
   assign m_sof   = m_valid && head[2];
   assign m_eol   = m_valid && head[1];
   assign m_eof   = m_valid && head[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe <= '0;
      end else if (flush) begin
         pipe <= '0;
      end else begin
         pipe[0] <= issue ? issue_tag : 4'b0;
         for (int i = 1; i < READ_LATENCY; i++)
            pipe[i] <= pipe[i-1];
      end
   end

   // Pixel storage needs no reset: occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {rd_pixel, pipe[READ_LATENCY-1][2:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rd_column <= '0;
         rd_row    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else if (flush) begin
         state     <= IDLE;
         rd_column <= '0;
         rd_row    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         done  <= pop && head_eof;
         count <= count + CW'(push) - CW'(pop);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         // Coordinates always wrap after the last one, so an idle controller
         // already points at (0,0) for the next frame.
         if (issue) begin
            if (last_col) begin
               rd_column <= '0;
               rd_row    <= last_row ? 32'd0 : rd_row + 32'd1;
            end else begin
               rd_column <= rd_column + 32'd1;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state <= ISSUE;
                  busy  <= 1'b1;
               end
            end
            ISSUE: begin
               if (issue && last_col && last_row && !repeat_now)
                  state <= DRAIN;
            end
            DRAIN: begin
               // eof is the last pixel, so its pop leaves nothing buffered.
               if (pop && head_eof) begin
                  state <= DONE;
                  busy  <= 1'b0;
               end
            end
            DONE: begin
               if (start) begin
                  state <= ISSUE;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_image_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_image_scan_controller
//   Drives image_scan_controller (4x3 frame, latency 2, depth 4) next to a
//   latency-2 loader model. A negedge monitor predicts every handshaked pixel
//   from its raster index and checks markers, stall stability, occupancy and
//   done timing; the main sequence runs the scenarios and prints one summary.
// -----------------------------------------------------------------------------
module tb_image_scan_controller;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int LAT   = 2;
   localparam int DEPTH = 4;
   localparam int N     = W * H;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        m_ready = 1'b0;
   logic        repeat_frame = 1'b0;
   logic        busy, done, m_valid, m_sof, m_eol, m_eof;
   logic [31:0] rd_column, rd_row;
   logic [23:0] rd_pixel, m_pixel;

   int checks = 0;
   int failures = 0;
   int rmode = 0;
   int cyc = 0;

   image_scan_controller #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef SCAN_FRAME_REPEAT_EN
      .repeat_frame(repeat_frame),
`endif
      .busy(busy), .done(done), .rd_column(rd_column), .rd_row(rd_row),
      .rd_pixel(rd_pixel), .m_valid(m_valid), .m_ready(m_ready),
      .m_pixel(m_pixel), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] pix(input int c, input int r);
      return 24'(c * 32'h010203 + r * 32'h0a0b0c + 32'h5a);
   endfunction

   // Loader: pixel for the coordinate presented LAT cycles earlier.
   logic [31:0] d1c = 0, d1r = 0, d2c = 0, d2r = 0;
   always @(posedge clk) begin
      d1c <= rd_column; d1r <= rd_row;
      d2c <= d1c;       d2r <= d1r;
   end
   assign rd_pixel = pix(int'(d2c), int'(d2r));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor / model ----------------
   int          exp_idx = 0, issued = 0, done_cnt = 0;
   int          sof_cnt = 0, eol_cnt = 0, eof_cnt = 0;
   int          lat = -1, start_cyc = 0;
   logic        armed = 0, abort_pend = 0, prev_eof_hs = 0, hold_v = 0;
   logic [31:0] prev_col = 0, prev_row = 0;
   logic [26:0] hold_d = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_idx = 0; issued = 0; armed = 0; abort_pend = 0;
         prev_eof_hs = 0; hold_v = 0; prev_col = 0; prev_row = 0;
      end else begin
         if (abort_pend) begin
            check("abort_valid", 32'(m_valid), 0);
            check("abort_busy", 32'(busy), 0);
            check("abort_done", 32'(done), 0);
            exp_idx = 0; issued = 0; hold_v = 0; prev_eof_hs = 0; armed = 0;
         end else begin
            if (rd_column != prev_col || rd_row != prev_row) issued++;
            if (done || prev_eof_hs) begin
               check("done_pulse", 32'(done), 32'(prev_eof_hs));
               if (done) done_cnt++;
            end
            if (hold_v)
               check("stall_stable", {4'(m_valid), m_pixel, m_sof, m_eol, m_eof}, {4'd1, hold_d});
            check("occupancy", 32'(issued - exp_idx <= DEPTH), 1);
            prev_eof_hs = 0;
            if (m_valid && m_ready) begin
               int k, c, r;
               k = exp_idx % N; c = k % W; r = k / W;
               $display("px %0d c=%0d r=%0d data=%06h sof=%0d eol=%0d eof=%0d",
                        exp_idx, c, r, m_pixel, m_sof, m_eol, m_eof);
               check("pixel", 32'(m_pixel), 32'(pix(c, r)));
               check("tags", {m_sof, m_eol, m_eof}, {k == 0, c == W - 1, k == N - 1});
               if (k == 0) check("pin_px0", 32'(m_pixel), 32'h00005A);
               if (k == 5) check("pin_px5", 32'(m_pixel), 32'h0B0D69);
               sof_cnt += int'(m_sof); eol_cnt += int'(m_eol); eof_cnt += int'(m_eof);
               prev_eof_hs = m_eof;
               exp_idx++;
            end
            hold_v = m_valid && !m_ready;
            hold_d = {m_pixel, m_sof, m_eol, m_eof};
            if (armed && m_valid) begin lat = cyc - start_cyc; armed = 0; end
            if (start && !busy) begin armed = 1; start_cyc = cyc + 1; lat = -1; end
         end
         prev_col = rd_column; prev_row = rd_row; abort_pend = abort;
      end
   end

   // ---------------- ready driver ----------------
   initial forever begin
      @(posedge clk); #1;
      case (rmode)
         0:       m_ready = 1'b1;
         1:       m_ready = ($urandom_range(0, 2) == 0);
         default: m_ready = 1'b0;
      endcase
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic nsample();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int d0);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 2000) begin nsample(); t++; end
      if (done_cnt == d0) check({name, "_timeout"}, 0, 1);
   endtask

   task automatic run_frame(input string name);
      int d0, x0;
      d0 = done_cnt; x0 = exp_idx;
      pulse_start();
      wait_done(name, d0);
      check({name, "_busy_low"}, 32'(busy), 0);
      check({name, "_count"}, 32'(exp_idx - x0), N);
      check({name, "_latency"}, 32'(lat), 3);
      step(2);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int s0, e0, f0, d0, bi, bx, bd, t, gaps, busy_low;
      rmode = 0;
      // Reset state
      rst_n = 1'b0;
      step(3);
      check("rst_col", rd_column, 0);
      check("rst_row", rd_row, 0);
      check("rst_flags", {busy, done, m_valid, m_sof, m_eol, m_eof}, 0);
      check("rst_pixel", 32'(m_pixel), 0);
      @(negedge clk); rst_n = 1'b1;
      step(2);

      // T1: full-rate frame
      s0 = sof_cnt; e0 = eol_cnt; f0 = eof_cnt;
      run_frame("t1");
      check("t1_sof_cnt", 32'(sof_cnt - s0), 1);
      check("t1_eol_cnt", 32'(eol_cnt - e0), 3);
      check("t1_eof_cnt", 32'(eof_cnt - f0), 1);

      // T2: random 1-of-3 ready
      rmode = 1;
      run_frame("t2");

      // T3: consumer stalled for 20 cycles
      rmode = 2; step(1);
      bi = issued; bx = exp_idx; d0 = done_cnt;
      pulse_start();
      step(20);
      check("t3_issued", 32'(issued - bi), DEPTH);
      check("t3_none_out", 32'(exp_idx - bx), 0);
      check("t3_valid", 32'(m_valid), 1);
      rmode = 0;
      wait_done("t3", d0);
      check("t3_count", 32'(exp_idx - bx), N);
      step(2);

      // T4: abort after pixel 5
      bx = exp_idx; d0 = done_cnt;
      pulse_start();
      t = 0;
      while (exp_idx - bx < 5 && t < 500) begin nsample(); t++; end
      check("t4_reach5", 32'(exp_idx - bx >= 5), 1);
      step(1); abort = 1'b1; step(1); abort = 1'b0;
      step(5);
      check("t4_no_done", 32'(done_cnt - d0), 0);
      check("t4_coord", {rd_column, rd_row} == 64'd0, 1);
      check("t4_idle_busy", 32'(busy), 0);
      check("t4_model_clear", 32'(exp_idx), 0);
      s0 = sof_cnt;
      run_frame("t4");
      check("t4_sof", 32'(sof_cnt - s0), 1);

      // T5: reset during drain
      rmode = 1;
      bi = issued; bx = exp_idx;
      pulse_start();
      t = 0;
      while (!(issued - bi == N && exp_idx - bx < N) && t < 500) begin nsample(); t++; end
      check("t5_in_drain", 32'(issued - bi == N && exp_idx - bx < N), 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_coord", {rd_column, rd_row} == 64'd0, 1);
      check("t5_rst_flags", {busy, done, m_valid, m_sof, m_eol, m_eof}, 0);
      check("t5_rst_pixel", 32'(m_pixel), 0);
      step(2); rst_n = 1'b1; step(2);
      check("t5_after_valid", 32'(m_valid), 0);
      check("t5_after_busy", 32'(busy), 0);
      rmode = 0;
      run_frame("t5");

`ifdef SCAN_FRAME_REPEAT_EN
      // T6: three back-to-back frames
      bi = issued; bx = exp_idx; bd = done_cnt; s0 = sof_cnt; f0 = eof_cnt;
      gaps = 0; busy_low = 0;
      repeat_frame = 1'b1;
      pulse_start();
      t = 0;
      while (done_cnt - bd < 3 && t < 1000) begin
         nsample(); t++;
         if (issued - bi >= 25) repeat_frame = 1'b0;
         if (!m_valid && exp_idx - bx > 0 && exp_idx - bx < 3 * N) gaps++;
         if (!busy && done_cnt - bd < 3) busy_low++;
      end
      check("t6_done_pulses", 32'(done_cnt - bd), 3);
      check("t6_count", 32'(exp_idx - bx), 3 * N);
      check("t6_sof", 32'(sof_cnt - s0), 3);
      check("t6_eof", 32'(eof_cnt - f0), 3);
      check("t6_gaps", 32'(gaps), 0);
      check("t6_busy_cont", 32'(busy_low), 0);
      check("t6_busy_end", 32'(busy), 0);
      step(2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
